// File: rtl/bcd_updown_counter.sv
// Cascadable up/down BCD counter: DIGITS decades with wrap or saturate at terminal count.
// Also provides a clamped parallel load, a sticky overflow flag and a load-error pulse.
module bcd_digit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] ld,
  input  logic       step,
  input  logic       up,
  output logic [3:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   q <= 4'd0;
    else if (clear) q <= 4'd0;
    else if (load)  q <= (ld > 4'd9) ? 4'd9 : ld;
    else if (step) begin
      if (up) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      else    q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end
endmodule

module bcd_updown_counter #(
  parameter int unsigned DIGITS = 3,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  done,
  output logic                  overflow,
  output logic                  load_err
);
  logic [DIGITS-1:0][3:0] digs;
  logic [DIGITS-1:0][3:0] lvd;
  logic [DIGITS:0]        all9, all0;
  logic [DIGITS-1:0]      step, bad;
  logic                   term, adv;

  assign lvd     = load_value;
  assign count   = digs;
  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  // all9[k]/all0[k]: every digit below k sits at 9/0, i.e. digit k is the next to ripple
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign all9[k+1] = all9[k] & (digs[k] == 4'd9);
    assign all0[k+1] = all0[k] & (digs[k] == 4'd0);
    assign bad[k]    = lvd[k] > 4'd9;
    assign step[k]   = adv & (up ? all9[k] : all0[k]);

    bcd_digit u_dig (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .load    (load),
      .ld      (lvd[k]),
      .step    (step[k]),
      .up      (up),
      .q       (digs[k])
    );
  end

  assign term = up ? all9[DIGITS] : all0[DIGITS];
  assign adv  = enable & ~clear & ~load & (WRAP | ~term);
  assign done = enable & term & ~clear & ~load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= ~clear & load & (|bad);
      if (clear)                        overflow <= 1'b0;
      else if (!load && enable && term) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed scenarios plus a randomized run scored against a decimal-arithmetic model.
module tb_bcd_updown_counter;
  logic        clk, reset_n, enable, up, clear, load, cen;
  logic [11:0] lv3, ca, cs;
  logic [3:0]  lv1, c1;
  logic [7:0]  clo, chi, zero8;
  logic        da, ds, d1, oa, os, o1, ea, es, e1;
  logic        lo_done, hi_done, lo_ov, hi_ov, lo_le, hi_le;
  int n_chk = 0, n_fail = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  assign zero8 = 8'd0;

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) dut_a (.clk(clk), .reset_n(reset_n),
    .enable(enable), .up(up), .clear(clear), .load(load), .load_value(lv3),
    .count(ca), .done(da), .overflow(oa), .load_err(ea));
  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0)) dut_s (.clk(clk), .reset_n(reset_n),
    .enable(enable), .up(up), .clear(clear), .load(load), .load_value(lv3),
    .count(cs), .done(ds), .overflow(os), .load_err(es));
  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) dut_1 (.clk(clk), .reset_n(reset_n),
    .enable(enable), .up(up), .clear(clear), .load(load), .load_value(lv1),
    .count(c1), .done(d1), .overflow(o1), .load_err(e1));
  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_lo (.clk(clk), .reset_n(reset_n),
    .enable(cen), .up(1'b1), .clear(1'b0), .load(1'b0), .load_value(zero8),
    .count(clo), .done(lo_done), .overflow(lo_ov), .load_err(lo_le));
  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_hi (.clk(clk), .reset_n(reset_n),
    .enable(lo_done), .up(1'b1), .clear(1'b0), .load(1'b0), .load_value(zero8),
    .count(chi), .done(hi_done), .overflow(hi_ov), .load_err(hi_le));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    for (int k = 0; k < d; k++) begin r[4*k +: 4] = 4'(v % 10); v = v / 10; end
    return r;
  endfunction

  function automatic int ld_val(input logic [31:0] lv, input int d);
    int v = 0;
    for (int k = d - 1; k >= 0; k--) v = v * 10 + ((lv[4*k +: 4] > 9) ? 9 : int'(lv[4*k +: 4]));
    return v;
  endfunction

  function automatic bit ld_bad(input logic [31:0] lv, input int d);
    bit b = 0;
    for (int k = 0; k < d; k++) if (lv[4*k +: 4] > 9) b = 1;
    return b;
  endfunction

  function automatic bit mterm(input int v, input int mx, input bit u);
    return u ? (v == mx) : (v == 0);
  endfunction

  function automatic int mnext(input int v, input int mx, input bit w, input bit clr,
                               input bit ld, input int ldv, input bit en, input bit u);
    if (clr) return 0;
    if (ld) return ldv;
    if (!en) return v;
    if (mterm(v, mx, u)) return w ? (u ? 0 : mx) : v;
    return u ? v + 1 : v - 1;
  endfunction

  function automatic bit movf(input bit ov, input int v, input int mx, input bit clr,
                              input bit ld, input bit en, input bit u);
    if (clr) return 0;
    if (!ld && en && mterm(v, mx, u)) return 1;
    return ov;
  endfunction

  initial begin
    int va, vs, v1, pva, pvs, pv1;
    bit ova, ovs, ov1, rc, rl, re, ru;
    int exp37[7] = '{4, 3, 2, 1, 0, 0, 0};
    logic [11:0] picks[5] = '{12'h999, 12'h000, 12'h998, 12'h001, 12'h000};

    // reset state, with done following count=0 while reset is held
    reset_n = 0; enable = 1; up = 0; clear = 0; load = 0; cen = 0; lv3 = 0; lv1 = 0;
    #2;
    chk("rst_count", ca, 0);
    chk("rst_ovf", oa, 0);
    chk("rst_lerr", ea, 0);
    chk("rst_done_down", da, 1);
    chk("rst_done_d1", d1, 1);
    #10;
    up = 1; reset_n = 1;

    // 1000 up steps from reset
    for (int i = 1; i <= 1000; i++) begin
      #1 chk("run_done", da, (i == 1000));
      @(posedge clk); #1;
      chk("run_count", ca, to_bcd(i % 1000, 3));
      chk("run_ovf", oa, (i == 1000));
    end

    // saturating countdown
    clear = 1; enable = 0;
    @(posedge clk); #1;
    chk("sat_clr_ovf", os, 0);
    clear = 0; load = 1; lv3 = 12'h005;
    @(posedge clk); #1;
    chk("sat_load", cs, 12'h005);
    load = 0; enable = 1; up = 0;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      chk("sat_count", cs, to_bcd(exp37[j], 3));
      chk("sat_done", ds, (exp37[j] == 0));
    end
    chk("sat_ovf", os, 1);

    // illegal load digit is clamped
    enable = 0; load = 1; lv3 = 12'h1A9;
    @(posedge clk); #1;
    chk("clamp_count", ca, 12'h199);
    chk("clamp_lerr", ea, 1);
    load = 0; enable = 1; up = 1;
    @(posedge clk); #1;
    chk("clamp_step", ca, 12'h200);
    chk("clamp_lerr_off", ea, 0);

    // clear dominates load and enable
    enable = 0; load = 1; lv3 = 12'h999;
    @(posedge clk); #1;
    load = 0; enable = 1;
    @(posedge clk); #1;
    chk("wrap_ovf", oa, 1);
    chk("wrap_count", ca, 12'h000);
    enable = 0; load = 1; lv3 = 12'h456;
    @(posedge clk); #1;
    chk("pri_pre", ca, 12'h456);
    clear = 1; load = 1; enable = 1;
    #1 chk("pri_done_gated", da, 0);
    @(posedge clk); #1;
    chk("pri_count", ca, 12'h000);
    chk("pri_ovf", oa, 0);
    chk("pri_lerr", ea, 0);

    // asynchronous reset between edges
    clear = 0; enable = 0; load = 1; lv3 = 12'h321;
    @(posedge clk); #1;
    chk("arst_pre", ca, 12'h321);
    #3 reset_n = 0;
    #1 chk("arst_count", ca, 12'h000);
    chk("arst_ovf", oa, 0);
    #2 reset_n = 1; load = 0; enable = 1; up = 1;
    repeat (3) @(posedge clk);
    #1 chk("arst_resume", ca, 12'h003);

    // randomized run scored against the model
    clear = 1;
    @(posedge clk); #1;
    va = 0; vs = 0; v1 = 0; ova = 0; ovs = 0; ov1 = 0;
    chk("rnd_init_a", ca, 0);
    chk("rnd_init_1", c1, 0);
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 19) == 0);
      rl = ($urandom_range(0, 5) == 0);
      re = ($urandom_range(0, 3) != 0);
      ru = 1'($urandom_range(0, 1));
      lv3 = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 4095)) : picks[$urandom_range(0, 4)];
      lv1 = 4'($urandom_range(0, 15));
      clear = rc; load = rl; enable = re; up = ru;
      #1;
      chk("rnd_done_a", da, re && !rc && !rl && mterm(va, 999, ru));
      chk("rnd_done_s", ds, re && !rc && !rl && mterm(vs, 999, ru));
      chk("rnd_done_1", d1, re && !rc && !rl && mterm(v1, 9, ru));
      pva = va; pvs = vs; pv1 = v1;
      va = mnext(pva, 999, 1, rc, rl, ld_val(32'(lv3), 3), re, ru);
      vs = mnext(pvs, 999, 0, rc, rl, ld_val(32'(lv3), 3), re, ru);
      v1 = mnext(pv1, 9, 1, rc, rl, ld_val(32'(lv1), 1), re, ru);
      ova = movf(ova, pva, 999, rc, rl, re, ru);
      ovs = movf(ovs, pvs, 999, rc, rl, re, ru);
      ov1 = movf(ov1, pv1, 9, rc, rl, re, ru);
      @(posedge clk); #1;
      chk("rnd_count_a", ca, to_bcd(va, 3));
      chk("rnd_count_s", cs, to_bcd(vs, 3));
      chk("rnd_count_1", c1, to_bcd(v1, 1));
      chk("rnd_ovf_a", oa, ova);
      chk("rnd_ovf_s", os, ovs);
      chk("rnd_ovf_1", o1, ov1);
      chk("rnd_lerr_a", ea, !rc && rl && ld_bad(32'(lv3), 3));
      chk("rnd_lerr_s", es, !rc && rl && ld_bad(32'(lv3), 3));
      chk("rnd_lerr_1", e1, !rc && rl && ld_bad(32'(lv1), 1));
    end
    clear = 0; load = 0; enable = 0;

    // two 2-digit stages cascaded through done
    cen = 1;
    for (int i = 1; i <= 10000; i++) begin
      if (i == 10000) begin
        chk("cas_lo_done", lo_done, 1);
        chk("cas_hi_done", hi_done, 1);
      end
      @(posedge clk); #1;
      chk("cas_count", {chi, clo}, to_bcd(i % 10000, 4));
    end
    cen = 0;
    chk("cas_lo_ovf", lo_ov, 1);
    chk("cas_hi_ovf", hi_ov, 1);
    chk("cas_lerr", {hi_le, lo_le}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
